// File: rtl/haz_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
package haz_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } haz_state_e;

   localparam int unsigned ZERO_REG = 0;

   // Wait-counter width; a zero-bit counter is not legal, so keep at least one bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for hazard_forward_ctrl; optional stats ports under HAZ_STATS_EN.
interface hazard_forward_ctrl_if #(
   parameter int unsigned REG_AW  = 3,
   parameter int unsigned NUM_SRC = 2
);

   logic                        pr1_valid;
   logic [NUM_SRC*REG_AW-1:0]   pr1_src;
   logic [NUM_SRC*REG_AW-1:0]   pr2_src;
   logic [REG_AW-1:0]           pr2_rd;
   logic                        pr2_RF_write_en;
   logic                        pr2_MEM_read;
   logic [REG_AW-1:0]           pr3_rd;
   logic                        pr3_RF_write_en;
   logic                        pr3_MEM_read;
   logic [REG_AW-1:0]           pr4_rd;
   logic                        pr4_RF_write_en;
   logic                        mem_ready;

   logic [NUM_SRC*2-1:0]        fwd_sel;
   logic                        stall_front;
   logic                        bubble_pr2;
   logic                        freeze_all;
   logic                        mem_timeout;
   logic [1:0]                  fsm_state;
`ifdef HAZ_STATS_EN
   logic [15:0]                 lu_stall_cnt;
   logic [15:0]                 freeze_cnt;
`endif

   modport master (
`ifdef HAZ_STATS_EN
      input  lu_stall_cnt, freeze_cnt,
`endif
      output pr1_valid, pr1_src, pr2_src, pr2_rd, pr2_RF_write_en, pr2_MEM_read,
      output pr3_rd, pr3_RF_write_en, pr3_MEM_read, pr4_rd, pr4_RF_write_en, mem_ready,
      input  fwd_sel, stall_front, bubble_pr2, freeze_all, mem_timeout, fsm_state
   );

   modport slave (
`ifdef HAZ_STATS_EN
      output lu_stall_cnt, freeze_cnt,
`endif
      input  pr1_valid, pr1_src, pr2_src, pr2_rd, pr2_RF_write_en, pr2_MEM_read,
      input  pr3_rd, pr3_RF_write_en, pr3_MEM_read, pr4_rd, pr4_RF_write_en, mem_ready,
      output fwd_sel, stall_front, bubble_pr2, freeze_all, mem_timeout, fsm_state
   );

endinterface

// File: rtl/haz_fwd_select.sv
// One operand's forwarding source: MEM (PR3, non-load) beats WB (PR4); r0 never forwards.
module haz_fwd_select
   import haz_pkg::*;
#(
   parameter int unsigned REG_AW = 3
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] pr3_rd,
   input  logic              pr3_RF_write_en,
   input  logic              pr3_MEM_read,
   input  logic [REG_AW-1:0] pr4_rd,
   input  logic              pr4_RF_write_en,
   output fwd_sel_e          sel_c
);

   logic src_nz_c;

   always_comb begin
      src_nz_c = (src != REG_AW'(ZERO_REG));
      sel_c    = FWD_RF;
      // A load in PR3 has no data yet, so it falls through to the PR4 compare.
      if (pr3_RF_write_en && !pr3_MEM_read && (pr3_rd == src) && src_nz_c) begin
         sel_c = FWD_MEM;
      end else if (pr4_RF_write_en && (pr4_rd == src) && src_nz_c) begin
         sel_c = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding, load-use stall and memory-wait freeze control for the 5-stage core.
// Optional saturating hazard statistics when HAZ_STATS_EN is defined.
module hazard_forward_ctrl
   import haz_pkg::*;
#(
   parameter int unsigned REG_AW  = 3,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   hazard_forward_ctrl_if.slave  bus
);

   localparam int unsigned      CNT_W    = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

   haz_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 mem_timeout_q, mem_timeout_d;

   logic [NUM_SRC*2-1:0] fwd_sel_c;
   logic                 src_match_c;
   logic                 lu_hit_c;
   logic                 freeze_c;
   logic                 err_c;
   logic                 stall_c;
   logic                 bubble_c;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      fwd_sel_e sel_c;

      haz_fwd_select #(.REG_AW(REG_AW)) u_sel (
         .src             (bus.pr2_src[i*REG_AW +: REG_AW]),
         .pr3_rd          (bus.pr3_rd),
         .pr3_RF_write_en (bus.pr3_RF_write_en),
         .pr3_MEM_read    (bus.pr3_MEM_read),
         .pr4_rd          (bus.pr4_rd),
         .pr4_RF_write_en (bus.pr4_RF_write_en),
         .sel_c           (sel_c)
      );

      assign fwd_sel_c[2*i +: 2] = sel_c;
   end

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      src_match_c = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.pr1_src[i*REG_AW +: REG_AW] == bus.pr2_rd) begin
            src_match_c = 1'b1;
         end
      end
      lu_hit_c = bus.pr1_valid && bus.pr2_MEM_read && bus.pr2_RF_write_en &&
                 (bus.pr2_rd != REG_AW'(ZERO_REG)) && src_match_c;
   end

   // Memory-wait FSM; freeze is Mealy so a missed load holds the pipe in its first cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      freeze_c = 1'b0;
      err_c    = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.pr3_MEM_read && !bus.mem_ready) begin
               freeze_c = 1'b1;
               state_d  = WAIT;
               cnt_d    = CNT_W'(1);
            end
         end
         WAIT: begin
            freeze_c = !bus.mem_ready;
            if (bus.mem_ready) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d = ERR;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ERR: begin
            freeze_c = 1'b1;
            err_c    = 1'b1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      // Freeze dominates: a load-use hit waits until the pipeline moves again.
      bubble_c      = lu_hit_c && !freeze_c;
      stall_c       = err_c || bubble_c;
      mem_timeout_d = (state_d == ERR) && (state_q != ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign bus.fwd_sel     = fwd_sel_c;
   assign bus.stall_front = stall_c;
   assign bus.bubble_pr2  = bubble_c;
   assign bus.freeze_all  = freeze_c;
   assign bus.mem_timeout = mem_timeout_q;
   assign bus.fsm_state   = state_q;

`ifdef HAZ_STATS_EN
   logic [15:0] lu_stall_cnt_q, lu_stall_cnt_d;
   logic [15:0] freeze_cnt_q, freeze_cnt_d;

   // Saturating event counters.
   always_comb begin
      lu_stall_cnt_d = lu_stall_cnt_q;
      freeze_cnt_d   = freeze_cnt_q;
      if (bubble_c && (lu_stall_cnt_q != 16'hFFFF)) begin
         lu_stall_cnt_d = lu_stall_cnt_q + 16'd1;
      end
      if (freeze_c && (freeze_cnt_q != 16'hFFFF)) begin
         freeze_cnt_d = freeze_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_stall_cnt_q <= '0;
         freeze_cnt_q   <= '0;
      end else begin
         lu_stall_cnt_q <= lu_stall_cnt_d;
         freeze_cnt_q   <= freeze_cnt_d;
      end
   end

   assign bus.lu_stall_cnt = lu_stall_cnt_q;
   assign bus.freeze_cnt   = freeze_cnt_q;
`endif

endmodule
